// File: rtl/filt_cicd_pkg.sv
// Shared helpers for the CIC decimator: ceil(log2) and the Hogenauer
// full-precision output width used as the default datapath width.
package filt_cicd_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Width that holds x*(R*M)^N without overflow for any x of inp_width bits.
  function automatic int cic_oup_width(input int inp_width, input int rate,
                                       input int order, input int diff_delay);
    return inp_width + order * clog2(rate * diff_delay);
  endfunction

endpackage

// File: rtl/filt_cicd_comb.sv
// One comb stage: o_data = i_data - i_data delayed by gp_diff_delay strobes.
// The subtract is combinational so a whole chain settles within the strobe
// cycle; only the delay line is registered and it shifts on strobe only.
module filt_cicd_comb
  import filt_cicd_pkg::*;
#(
  parameter int gp_width      = 14,
  parameter int gp_diff_delay = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_an,
  input  logic                i_strobe,
  input  logic [gp_width-1:0] i_data,
  output logic [gp_width-1:0] o_data
);

  logic [gp_diff_delay-1:0][gp_width-1:0] dly_q, dly_d;

  // Shift the delay line by one decimated sample on each strobe.
  always_comb begin
    dly_d = dly_q;
    if (i_strobe) begin
      dly_d[0] = i_data;
      for (int i = 1; i < gp_diff_delay; i++) dly_d[i] = dly_q[i-1];
    end
  end

  // Delay-line registers with synchronous active-low clear.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) dly_q <= '0;
    else           dly_q <= dly_d;
  end

  // Modulo subtraction; wrap in the integrators cancels out here.
  assign o_data = i_data - dly_q[gp_diff_delay-1];

endmodule

// File: rtl/filt_cicd.sv
// CIC decimator: N pipelined integrators at input rate, a slot counter that
// picks one sample in every R, and N comb stages running on that strobe.
// The comb result is registered into o_data with a one-cycle o_valid pulse.
module filt_cicd
  import filt_cicd_pkg::*;
#(
  parameter int gp_decimation_factor = 4,
  parameter int gp_order             = 3,
  parameter int gp_diff_delay        = 1,
  parameter int gp_phase             = 0,
  parameter int gp_inp_width         = 8,
  parameter int gp_oup_width         = cic_oup_width(gp_inp_width, gp_decimation_factor,
                                                     gp_order, gp_diff_delay)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_an,
  input  logic                    i_ena,
  input  logic [gp_inp_width-1:0] i_data,
  output logic [gp_oup_width-1:0] o_data,
  output logic                    o_valid
);

  localparam int                  lp_cnt_w     = clog2(gp_decimation_factor);
  localparam logic [lp_cnt_w-1:0] lp_cnt_last  = lp_cnt_w'(gp_decimation_factor - 1);
  localparam logic [lp_cnt_w-1:0] lp_cnt_phase = lp_cnt_w'(gp_phase);

  logic [gp_oup_width-1:0]               data_ext;
  logic [gp_order-1:0][gp_oup_width-1:0] acc_q, acc_d;
  logic [lp_cnt_w-1:0]                   cnt_q, cnt_d;
  logic [gp_oup_width-1:0]               o_data_q, o_data_d;
  logic                                  o_valid_q, o_valid_d;
  logic                                  strobe;
  logic [gp_oup_width-1:0]               comb_out;

  assign data_ext = gp_oup_width'($signed(i_data));
  assign strobe   = i_ena && (cnt_q == lp_cnt_phase);

  // Integrator chain; each stage adds the previous stage's registered value.
  always_comb begin
    acc_d = acc_q;
    if (i_ena) begin
      acc_d[0] = acc_q[0] + data_ext;
      for (int k = 1; k < gp_order; k++) acc_d[k] = acc_q[k] + acc_q[k-1];
    end
  end

  // Slot counter 0..R-1, advancing only on accepted samples.
  always_comb begin
    cnt_d = cnt_q;
    if (i_ena) cnt_d = (cnt_q == lp_cnt_last) ? '0 : cnt_q + 1'b1;
  end

  // Comb chain fed by the last integrator's registered output.
  for (genvar k = 0; k < gp_order; k++) begin : g_comb
    logic [gp_oup_width-1:0] stage_in;
    logic [gp_oup_width-1:0] stage_out;
    if (k == 0) begin : g_first
      assign stage_in = acc_q[gp_order-1];
    end else begin : g_next
      assign stage_in = g_comb[k-1].stage_out;
    end
    filt_cicd_comb #(
      .gp_width      (gp_oup_width),
      .gp_diff_delay (gp_diff_delay)
    ) u_comb (
      .i_clk    (i_clk),
      .i_rst_an (i_rst_an),
      .i_strobe (strobe),
      .i_data   (stage_in),
      .o_data   (stage_out)
    );
  end

  assign comb_out = g_comb[gp_order-1].stage_out;

  // Capture the comb result on strobe; hold it otherwise.
  always_comb begin
    o_data_d  = o_data_q;
    o_valid_d = strobe;
    if (strobe) o_data_d = comb_out;
  end

  // State registers; synchronous active-low reset overrides i_ena.
  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_filt_cicd.sv
// Bench for filt_cicd with R=4, N=3, M=1, 8-bit in, 14-bit out.
// Four instances differ only in gp_phase; instance 0 (phase 0) carries the
// main tests. Reference is the equivalent FIR: output on a strobe at accepted
// sample n equals sum_k h[k]*x[n-3-k], h = (1+z^-1+z^-2+z^-3)^3.
module tb_filt_cicd;

  logic        clk;
  logic        rst_an;
  logic        ena;
  logic [7:0]  din;
  logic [13:0] dut_data  [4];
  logic        dut_valid [4];

  int checks;
  int errors;

  int h_tab [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
  int xs [16384];
  int n_acc;
  int last_exp;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    filt_cicd #(
      .gp_decimation_factor (4),
      .gp_order             (3),
      .gp_diff_delay        (1),
      .gp_phase             (p),
      .gp_inp_width         (8)
    ) u_dut (
      .i_clk    (clk),
      .i_rst_an (rst_an),
      .i_ena    (ena),
      .i_data   (din),
      .o_data   (dut_data[p]),
      .o_valid  (dut_valid[p])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at the falling edge, return at the next falling edge so the
  // outputs seen by the caller reflect the rising edge just taken.
  task automatic step(input logic rst_v, input logic en_v, input logic signed [7:0] d_v);
    rst_an = rst_v;
    ena    = en_v;
    din    = d_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 8'sd0);
    step(1'b0, 1'b0, 8'sd0);
    n_acc    = 0;
    last_exp = 0;
  endtask

  function automatic int fir_ref(input int n);
    int acc;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      if (n - 3 - k >= 0) acc += h_tab[k] * xs[n-3-k];
    end
    return acc;
  endfunction

  // Drives one cycle and returns what the phase-0 instance should show.
  task automatic model_step(input logic en_v, input logic signed [7:0] d_v,
                            output logic exp_valid, output int exp_val);
    exp_valid = en_v && ((n_acc % 4) == 0);
    if (en_v) xs[n_acc] = int'(d_v);
    if (exp_valid) last_exp = fir_ref(n_acc);
    exp_val = last_exp;
    if (en_v) n_acc++;
    step(1'b1, en_v, d_v);
  endtask

  function automatic int act0();
    return int'($signed(dut_data[0]));
  endfunction

  task automatic test_reset();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (dut_data[p] !== 14'd0) begin
        errors++;
        $display("FAIL reset_data p%0d: got %0d want 0", p, dut_data[p]);
      end
      checks++;
      if (dut_valid[p] !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid p%0d: got %b want 0", p, dut_valid[p]);
      end
    end
  endtask

  task automatic test_dc_one();
    logic ev;
    int   evl;
    int   nvalid;
    do_reset();
    nvalid = 0;
    for (int i = 0; i < 48; i++) begin
      model_step(1'b1, 8'sd1, ev, evl);
      checks++;
      if (dut_valid[0] !== ev || act0() !== evl) begin
        errors++;
        $display("FAIL dc_one step%0d: got v=%b d=%0d want v=%b d=%0d", i, dut_valid[0], act0(), ev, evl);
      end
      if (i >= 32 && dut_valid[0] === 1'b1) nvalid++;
    end
    checks++;
    if (act0() !== 64) begin
      errors++;
      $display("FAIL dc_one_settle: got %0d want 64", act0());
    end
    checks++;
    if (nvalid !== 4) begin
      errors++;
      $display("FAIL dc_one_rate: got %0d pulses in 16 cycles want 4", nvalid);
    end
  endtask

  task automatic test_full_scale();
    logic ev;
    int   evl;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      model_step(1'b1, (i < 40) ? 8'sd127 : -8'sd128, ev, evl);
      checks++;
      if (dut_valid[0] !== ev || act0() !== evl) begin
        errors++;
        $display("FAIL full_scale step%0d: got v=%b d=%0d want v=%b d=%0d", i, dut_valid[0], act0(), ev, evl);
      end
      if (i == 39) begin
        checks++;
        if (act0() !== 8128) begin
          errors++;
          $display("FAIL full_scale_pos: got %0d want 8128", act0());
        end
      end
    end
    checks++;
    if (act0() !== -8192) begin
      errors++;
      $display("FAIL full_scale_neg: got %0d want -8192", act0());
    end
  endtask

  task automatic test_impulse();
    int exp_tab [4][5] = '{'{0, 3, 12, 1, 0},
                           '{0, 6, 10, 0, 0},
                           '{0, 10, 6, 0, 0},
                           '{1, 12, 3, 0, 0}};
    int got [4][8];
    int nv [4];
    int sum;
    do_reset();
    for (int p = 0; p < 4; p++) nv[p] = 0;
    for (int i = 0; i < 21; i++) begin
      step(1'b1, 1'b1, (i == 0) ? 8'sd1 : 8'sd0);
      for (int p = 0; p < 4; p++) begin
        if (dut_valid[p] === 1'b1 && nv[p] < 8) begin
          got[p][nv[p]] = int'($signed(dut_data[p]));
          nv[p]++;
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (nv[p] < 5) begin
        errors++;
        $display("FAIL impulse_count p%0d: got %0d strobes want >=5", p, nv[p]);
      end else begin
        sum = 0;
        for (int j = 0; j < 5; j++) begin
          sum += got[p][j];
          checks++;
          if (got[p][j] !== exp_tab[p][j]) begin
            errors++;
            $display("FAIL impulse p%0d out%0d: got %0d want %0d", p, j, got[p][j], exp_tab[p][j]);
          end
        end
        checks++;
        if (sum !== 16) begin
          errors++;
          $display("FAIL impulse_sum p%0d: got %0d want 16", p, sum);
        end
      end
    end
  endtask

  task automatic test_ena_gaps();
    logic        ev;
    int          evl;
    logic [15:0] lfsr;
    int          last_act;
    do_reset();
    lfsr     = 16'hACE1;
    last_act = 0;
    for (int i = 0; i < 240; i++) begin
      model_step(lfsr[0] | (i >= 200), 8'sd5, ev, evl);
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      checks++;
      if (dut_valid[0] !== ev || act0() !== evl) begin
        errors++;
        $display("FAIL ena_gaps step%0d: got v=%b d=%0d want v=%b d=%0d", i, dut_valid[0], act0(), ev, evl);
      end
      if (dut_valid[0] === 1'b1) last_act = act0();
    end
    checks++;
    if (last_act !== 320) begin
      errors++;
      $display("FAIL ena_gaps_settle: got %0d want 320", last_act);
    end
  endtask

  task automatic test_random();
    logic             ev;
    int               evl;
    logic signed [7:0] rd;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      rd = 8'($urandom_range(0, 255));
      model_step(1'b1, rd, ev, evl);
      checks++;
      if (dut_valid[0] !== ev || act0() !== evl) begin
        errors++;
        $display("FAIL random step%0d: got v=%b d=%0d want v=%b d=%0d", i, dut_valid[0], act0(), ev, evl);
      end
    end
  endtask

  // Reset for one cycle with i_ena high; calling the reset cycle cycle 0,
  // the first pulse for phase p is expected in cycle p+2.
  task automatic test_reset_mid();
    int first [4];
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'sd3);
    step(1'b0, 1'b1, 8'sd3);
    for (int p = 0; p < 4; p++) begin
      first[p] = -1;
      checks++;
      if (dut_data[p] !== 14'd0 || dut_valid[p] !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_clear p%0d: got d=%0d v=%b want 0/0", p, dut_data[p], dut_valid[p]);
      end
    end
    for (int c = 2; c < 8; c++) begin
      step(1'b1, 1'b1, 8'sd3);
      for (int p = 0; p < 4; p++) begin
        if (dut_valid[p] === 1'b1 && first[p] < 0) first[p] = c;
      end
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (first[p] !== p + 2) begin
        errors++;
        $display("FAIL reset_mid_first p%0d: got cycle %0d want %0d", p, first[p], p + 2);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_an = 1'b0;
    ena    = 1'b0;
    din    = 8'd0;
    @(negedge clk);
    test_reset();
    test_dc_one();
    test_full_scale();
    test_impulse();
    test_ena_gaps();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
